// File: rtl/ext_mem_mc.sv
// Multi-channel word-addressed, byte-maskable memory: a round-robin arbiter feeds one shared
// array, and each channel has its own in-order response FIFO guarded by credits.
module ext_mem_mc #(
  parameter int NCHAN         = 2,
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int RESP_DEPTH    = 2,
  localparam int BE_W  = DATA_WIDTH / 8,
  localparam int REQ_W = BE_W + 32 + DATA_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NCHAN-1:0]       put_valid,
  input  logic [NCHAN*REQ_W-1:0] put_request,
  output logic [NCHAN-1:0]       put_ready,
  input  logic [NCHAN-1:0]       get_valid,
  output logic [NCHAN-1:0]       get_ready,
  output logic [NCHAN*REQ_W-1:0] get_response
);
  // Handshake: put_ready[i] is the one-hot grant and depends combinationally on put_valid;
  // a request transfers on a clock edge where put_valid[i] & put_ready[i]. A response is
  // dequeued on an edge where get_valid[i] & get_ready[i]; get_valid alone is ignored.
  localparam int BE_LSB = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int WORDS  = 1 << ADDRESS_WIDTH;
  localparam int CH_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  s1_valid;
  logic [CH_W-1:0]       s1_chan;
  logic [BE_W-1:0]       s1_be;
  logic [31:0]           s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CH_W-1:0]       rr_ptr;

  logic [REQ_W-1:0] fifo_q [NCHAN][RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NCHAN];
  logic [PTR_W-1:0] rd_ptr [NCHAN];
  logic [CNT_W-1:0] count  [NCHAN];

  logic [NCHAN-1:0]         eligible;
  logic [NCHAN-1:0]         grant;
  logic [NCHAN-1:0]         push;
  logic [NCHAN-1:0]         pop;
  logic                     grant_found;
  logic [CH_W-1:0]          grant_chan;
  logic [REQ_W-1:0]         req;
  logic [BE_W-1:0]          req_be;
  logic [31:0]              req_addr;
  logic [DATA_WIDTH-1:0]    req_data;
  logic [ADDRESS_WIDTH-1:0] req_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A slot is reserved for the response still sitting in s1, so a push can never overflow.
  always_comb begin
    eligible = '0;
    push     = '0;
    pop      = '0;
    for (int i = 0; i < NCHAN; i++) begin
      push[i]     = s1_valid && (s1_chan == CH_W'(i));
      pop[i]      = get_valid[i] && (count[i] != '0);
      eligible[i] = put_valid[i] &&
                    (int'(count[i]) + (push[i] ? 1 : 0) < RESP_DEPTH);
    end
  end

  always_comb begin : arb
    int c;
    c           = 0;
    grant       = '0;
    grant_found = 1'b0;
    grant_chan  = '0;
    for (int k = 0; k < NCHAN; k++) begin
      c = (int'(rr_ptr) + k) % NCHAN;
      if (!grant_found && eligible[c] && RST_N) begin
        grant_found = 1'b1;
        grant_chan  = CH_W'(c);
        grant[c]    = 1'b1;
      end
    end
  end

  assign put_ready = grant;
  assign req       = put_request[grant_chan*REQ_W +: REQ_W];
  assign req_be    = req[REQ_W-1 -: BE_W];
  assign req_addr  = req[DATA_WIDTH +: 32];
  assign req_data  = req[DATA_WIDTH-1:0];
  assign req_idx   = req_addr[BE_LSB +: ADDRESS_WIDTH];

  // Array contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (grant_found) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) mem[req_idx][b*8 +: 8] <= req_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_chan  <= '0;
      s1_be    <= '0;
      s1_addr  <= '0;
      s1_data  <= '0;
      rr_ptr   <= '0;
    end else begin
      s1_valid <= grant_found;
      if (grant_found) begin
        s1_chan <= grant_chan;
        s1_be   <= req_be;
        s1_addr <= req_addr;
        s1_data <= (req_be == '0) ? mem[req_idx] : req_data;
        rr_ptr  <= (int'(grant_chan) == NCHAN - 1) ? '0 : grant_chan + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (s1_valid) fifo_q[s1_chan][wr_ptr[s1_chan]] <= {s1_be, s1_addr, s1_data};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NCHAN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_comb begin
    get_ready    = '0;
    get_response = '0;
    for (int i = 0; i < NCHAN; i++) begin
      get_ready[i] = (count[i] != '0);
      if (count[i] != '0) get_response[i*REQ_W +: REQ_W] = fifo_q[i][rd_ptr[i]];
    end
  end
endmodule

// File: tb/tb_ext_mem_mc.sv
// Directed bench for ext_mem_mc: a RESP_DEPTH=2 instance for the main sequence and a
// RESP_DEPTH=1 instance for the streaming case.
module tb_ext_mem_mc;
  localparam int REQ_W = 68;

  logic clk;
  logic rst_n;

  logic [1:0]         pv, pr, gv, gr;
  logic [2*REQ_W-1:0] preq, gresp;
  logic [1:0]         d_pv, d_pr, d_gv, d_gr;
  logic [2*REQ_W-1:0] d_preq, d_gresp;

  int checks = 0;
  int errors = 0;
  logic [REQ_W-1:0] exp_q[3][$];

  logic [31:0] rr_addr [4] = '{32'h80, 32'h84, 32'h40, 32'h80};
  logic [31:0] rr_data [4] = '{32'h11223344, 32'hA5A5A5A5, 32'hDEAD55EF, 32'h11223344};
  int          rd_idx  [8] = '{3, 0, 2, 1, 0, 1, 2, 3};
  logic [REQ_W-1:0] s_req [12];
  logic [REQ_W-1:0] s_exp [12];

  int i0, i1, n_acc, scyc, last_acc;

  ext_mem_mc #(.NCHAN(2), .ADDRESS_WIDTH(14), .DATA_WIDTH(32), .RESP_DEPTH(2)) dut (
    .CLK(clk), .RST_N(rst_n), .put_valid(pv), .put_request(preq), .put_ready(pr),
    .get_valid(gv), .get_ready(gr), .get_response(gresp)
  );

  ext_mem_mc #(.NCHAN(2), .ADDRESS_WIDTH(14), .DATA_WIDTH(32), .RESP_DEPTH(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .put_valid(d_pv), .put_request(d_preq), .put_ready(d_pr),
    .get_valid(d_gv), .get_ready(d_gr), .get_response(d_gresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk(input logic [3:0] be, input logic [31:0] a,
                                          input logic [31:0] d);
    return {be, a, d};
  endfunction

  task automatic chk(input string tag, input logic [2*REQ_W-1:0] obs,
                     input logic [2*REQ_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int q, input logic [REQ_W-1:0] obs);
    logic [REQ_W-1:0] e;
    checks++;
    assert (exp_q[q].size() != 0) else begin
      errors++;
      $error("FAIL resp_q%0d: observed %0h expected no response", q, obs);
    end
    if (exp_q[q].size() != 0) begin
      e = exp_q[q].pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL resp_q%0d: observed %0h expected %0h", q, obs, e);
      end
    end
  endtask

  // Scoreboard: every dequeued response is compared against the expected queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gr[0] && gv[0]) mon(0, gresp[0 +: REQ_W]);
      if (gr[1] && gv[1]) mon(1, gresp[REQ_W +: REQ_W]);
      if (d_gr[0] && d_gv[0]) mon(2, d_gresp[0 +: REQ_W]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input int ch, input logic [REQ_W-1:0] r, input logic [REQ_W-1:0] e);
    int n;
    n = 0;
    pv[ch] = 1'b1;
    preq[ch*REQ_W +: REQ_W] = r;
    @(negedge clk);
    while (!pr[ch] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 136'(pr[ch]), 136'(1));
    if (pr[ch]) exp_q[ch].push_back(e);
    @(posedge clk);
    #1;
    pv[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 4; j++) begin
      s_req[j] = mk(4'hF, 32'h10 + 4*j, 32'h01010101 * (j + 1));
      s_exp[j] = s_req[j];
    end
    for (int m = 0; m < 8; m++) begin
      s_req[4+m] = mk(4'h0, 32'h10 + 4*rd_idx[m], 32'h0);
      s_exp[4+m] = mk(4'h0, 32'h10 + 4*rd_idx[m], 32'h01010101 * (rd_idx[m] + 1));
    end

    // Reset with every channel requesting.
    rst_n = 1'b0; pv = 2'b11; gv = 2'b00; d_pv = 2'b00; d_gv = 2'b00; d_preq = '0;
    preq = {mk(4'hF, 32'h84, 32'hA5A5A5A5), mk(4'hF, 32'h80, 32'h11223344)};
    @(negedge clk);
    chk("rst_put_ready", 136'(pr), 136'(0));
    chk("rst_get_ready", 136'(gr), 136'(0));
    chk("rst_get_response", gresp, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 136'(pr), 136'(2'b01));
    exp_q[0].push_back(mk(4'hF, 32'h80, 32'h11223344));
    @(posedge clk); #1;
    pv = 2'b10;
    @(negedge clk);
    chk("second_grant", 136'(pr), 136'(2'b10));
    exp_q[1].push_back(mk(4'hF, 32'h84, 32'hA5A5A5A5));
    @(posedge clk); #1;
    pv = 2'b00; gv = 2'b11;
    cyc(4);

    // Full write, partial write, then a read merging both.
    offer(1, mk(4'hF, 32'h40, 32'hDEADBEEF), mk(4'hF, 32'h40, 32'hDEADBEEF));
    offer(1, mk(4'b0010, 32'h40, 32'h00005500), mk(4'b0010, 32'h40, 32'h00005500));
    pv[0] = 1'b1;
    preq[0 +: REQ_W] = mk(4'h0, 32'h40, 32'h0);
    @(negedge clk);
    chk("rd_grant", 136'(pr), 136'(2'b01));
    exp_q[0].push_back(mk(4'h0, 32'h40, 32'hDEAD55EF));
    @(posedge clk); #1;
    pv[0] = 1'b0;
    @(negedge clk);
    chk("rd_lat_e0", 136'(gr[0]), 136'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_lat_e1", 136'(gr[0]), 136'(1));
    chk("rd_data", 136'(gresp[0 +: REQ_W]), 136'(mk(4'h0, 32'h40, 32'hDEAD55EF)));
    cyc(4);

    // Round robin: ch0 reads, ch1 writes distinct echoes; rr_ptr starts at 1.
    i0 = 0; i1 = 0; pv = 2'b11;
    preq[0 +: REQ_W]     = mk(4'h0, rr_addr[0], 32'h0);
    preq[REQ_W +: REQ_W] = mk(4'hF, 32'h200, 32'h1000);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 136'(pr), (k % 2 == 0) ? 136'(2'b10) : 136'(2'b01));
      if (pr[0]) begin
        exp_q[0].push_back(mk(4'h0, rr_addr[i0 % 4], rr_data[i0 % 4]));
        i0++;
      end
      if (pr[1]) begin
        exp_q[1].push_back(mk(4'hF, 32'h200, 32'h1000 + i1));
        i1++;
      end
      @(posedge clk); #1;
      preq[0 +: REQ_W]     = mk(4'h0, rr_addr[i0 % 4], 32'h0);
      preq[REQ_W +: REQ_W] = mk(4'hF, 32'h200, 32'h1000 + i1);
    end
    pv = 2'b00;
    cyc(5);

    // Back-pressure: ch0 consumer stalled, reads queued on ch0.
    gv = 2'b10; pv = 2'b01; n_acc = 0;
    preq[0 +: REQ_W] = mk(4'h0, rr_addr[0], 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (pr[0]) begin
        exp_q[0].push_back(mk(4'h0, rr_addr[n_acc % 4], rr_data[n_acc % 4]));
        n_acc++;
      end
      @(posedge clk); #1;
      preq[0 +: REQ_W] = mk(4'h0, rr_addr[n_acc % 4], 32'h0);
    end
    @(negedge clk);
    chk("bp_accepts", 136'(n_acc), 136'(2));
    chk("bp_ready", 136'(gr[0]), 136'(1));
    chk("bp_head", 136'(gresp[0 +: REQ_W]), 136'(mk(4'h0, 32'h80, 32'h11223344)));
    @(posedge clk); #1;
    gv[0] = 1'b1;
    @(negedge clk);
    chk("bp_hold", 136'(pr[0]), 136'(0));
    @(posedge clk); #1;
    gv[0] = 1'b0;
    @(negedge clk);
    chk("bp_third", 136'(pr[0]), 136'(1));
    if (pr[0]) exp_q[0].push_back(mk(4'h0, rr_addr[n_acc % 4], rr_data[n_acc % 4]));
    @(posedge clk); #1;
    pv = 2'b00; gv = 2'b11;
    cyc(6);

    // Streaming on the single-entry instance: 4 writes then 8 reads.
    d_gv = 2'b11; d_pv = 2'b01; n_acc = 0; scyc = 0; last_acc = 0;
    d_preq[0 +: REQ_W] = s_req[0];
    while (n_acc < 12 && scyc < 80) begin
      @(negedge clk);
      chk("strm_credit", 136'(d_pr[0] & d_gr[0]), 136'(0));
      if (d_pr[0]) begin
        if (n_acc > 0) chk("strm_gap", 136'(scyc - last_acc >= 2), 136'(1));
        exp_q[2].push_back(s_exp[n_acc]);
        last_acc = scyc;
        n_acc++;
      end
      @(posedge clk); #1;
      scyc++;
      d_preq[0 +: REQ_W] = s_req[n_acc % 12];
    end
    chk("strm_all_accepted", 136'(n_acc), 136'(12));
    d_pv = 2'b00;
    cyc(6);

    // Asynchronous reset with s1 and a FIFO both occupied.
    gv = 2'b00;
    offer(1, mk(4'hF, 32'h300, 32'hCAFEF00D), mk(4'hF, 32'h300, 32'hCAFEF00D));
    offer(0, mk(4'h0, 32'h80, 32'h0), mk(4'h0, 32'h80, 32'h11223344));
    chk("pre_rst_ready", 136'(gr), 136'(2'b10));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 136'(gr), 136'(0));
    chk("arst_resp", gresp, '0);
    exp_q[0].delete();
    exp_q[1].delete();
    pv = 2'b11;
    @(negedge clk);
    chk("arst_put_ready", 136'(pr), 136'(0));
    @(posedge clk); #1;
    pv = 2'b00; gv = 2'b11;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale", 136'(gr), 136'(0));
    end
    @(posedge clk); #1;
    offer(0, mk(4'h0, 32'h300, 32'h0), mk(4'h0, 32'h300, 32'hCAFEF00D));
    cyc(5);

    chk("q0_drained", 136'(exp_q[0].size()), 136'(0));
    chk("q1_drained", 136'(exp_q[1].size()), 136'(0));
    chk("q2_drained", 136'(exp_q[2].size()), 136'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
